// File: rtl/pong_engine.sv
// Pong game core: ball/paddle positions, scores and SERVE/PLAY/POINT/GAME_OVER FSM, one step per tick.
// Latency: a tick sampled at edge N is visible on the registered outputs right after edge N.
// Backpressure: none; the core advances only on tick and accepts every tick. Define CPU_PLAYER_EN for a computer-driven right paddle.
module pong_engine #(
  parameter int COORD_W      = 10,
  parameter int H_RES        = 640,
  parameter int V_RES        = 480,
  parameter int PADDLE_H     = 64,
  parameter int PADDLE_W     = 8,
  parameter int PADDLE_X_OFS = 16,
  parameter int BALL_SIZE    = 8,
  parameter int PADDLE_SPEED = 4,
  parameter int BALL_SPEED   = 2,
  parameter int SCORE_W      = 4,
  parameter int WIN_SCORE    = 9,
  parameter int SERVE_TICKS  = 60,
  parameter int CPU_SPEED    = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               btn_l_up,
  input  logic               btn_l_dwn,
  input  logic               btn_r_up,
  input  logic               btn_r_dwn,
  input  logic               start,
  output logic [COORD_W-1:0] ball_x,
  output logic [COORD_W-1:0] ball_y,
  output logic [COORD_W-1:0] l_paddle_y,
  output logic [COORD_W-1:0] r_paddle_y,
  output logic [SCORE_W-1:0] score_l,
  output logic [SCORE_W-1:0] score_r,
  output logic [1:0]         state,
  output logic               game_over
);

  // One extra bit of headroom so "position + step" comparisons never overflow.
  typedef logic [COORD_W:0]   wide_t;
  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [1:0] {
    SERVE     = 2'd0,
    PLAY      = 2'd1,
    POINT     = 2'd2,
    GAME_OVER = 2'd3
  } state_t;

  localparam int CNT_W = (SERVE_TICKS > 1) ? $clog2(SERVE_TICKS) : 1;

  localparam coord_t X_CTR   = coord_t'(H_RES / 2 - BALL_SIZE / 2);
  localparam coord_t Y_CTR   = coord_t'(V_RES / 2 - BALL_SIZE / 2);
  localparam coord_t P_CTR   = coord_t'((V_RES - PADDLE_H) / 2);
  localparam coord_t P_MAX   = coord_t'(V_RES - PADDLE_H);
  localparam coord_t Y_MAX_N = coord_t'(V_RES - BALL_SIZE);
  localparam coord_t BSPD_N  = coord_t'(BALL_SPEED);
  localparam coord_t LFACE_N = coord_t'(PADDLE_X_OFS + PADDLE_W);
  localparam coord_t RFACE_N = coord_t'(H_RES - PADDLE_X_OFS - PADDLE_W - BALL_SIZE);

  localparam wide_t P_MAX_W = wide_t'(V_RES - PADDLE_H);
  localparam wide_t Y_MAX   = wide_t'(V_RES - BALL_SIZE);
  localparam wide_t X_MAX   = wide_t'(H_RES - BALL_SIZE);
  localparam wide_t BSPD    = wide_t'(BALL_SPEED);
  localparam wide_t PSPD    = wide_t'(PADDLE_SPEED);
  localparam wide_t BSZ     = wide_t'(BALL_SIZE);
  localparam wide_t PH      = wide_t'(PADDLE_H);
  localparam wide_t LFACE   = wide_t'(PADDLE_X_OFS + PADDLE_W);
  localparam wide_t RFACE   = wide_t'(H_RES - PADDLE_X_OFS - PADDLE_W - BALL_SIZE);

  localparam logic [SCORE_W-1:0] WIN      = SCORE_W'(WIN_SCORE);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(SERVE_TICKS - 1);

  // Reject configurations the counters cannot represent.
  generate
    if (WIN_SCORE > (2 ** SCORE_W) - 1 || WIN_SCORE < 1) begin : g_bad_win
      $error("pong_engine: WIN_SCORE must be 1..2**SCORE_W-1");
    end
    if (PADDLE_SPEED < 1 || BALL_SPEED < 1 || CPU_SPEED < 1) begin : g_bad_speed
      $error("pong_engine: speeds must be at least 1");
    end
  endgenerate

  state_t             st;
  logic [CNT_W-1:0]   cnt;
  logic               dx_right;     // 1: ball moving right (+x)
  logic               dy_down;      // 1: ball moving down (+y)
  logic               left_scored;  // who won the last point, consumed in POINT

  // Saturating paddle step shared by human and CPU control.
  function automatic coord_t paddle_step(input coord_t y, input logic up, input logic dn,
                                         input wide_t spd);
    wide_t yw;
    yw = {1'b0, y};
    if (up && !dn)
      return (yw < spd) ? '0 : coord_t'(yw - spd);
    else if (dn && !up)
      return (yw + spd > P_MAX_W) ? P_MAX : coord_t'(yw + spd);
    else
      return y;
  endfunction

  wide_t  bx, by, ly, ry;
  logic   l_overlap, r_overlap;
  coord_t l_next, r_next;

  assign bx = {1'b0, ball_x};
  assign by = {1'b0, ball_y};
  assign ly = {1'b0, l_paddle_y};
  assign ry = {1'b0, r_paddle_y};

  // Overlap uses the paddle position before this tick's move.
  assign l_overlap = (by + BSZ > ly) && (by < ly + PH);
  assign r_overlap = (by + BSZ > ry) && (by < ry + PH);

  assign l_next = paddle_step(l_paddle_y, btn_l_up, btn_l_dwn, PSPD);

`ifdef CPU_PLAYER_EN
  localparam wide_t CSPD = wide_t'(CPU_SPEED);
  wide_t pc, bc;
  logic  cpu_up, cpu_dn;
  logic  unused_btn_r;

  assign unused_btn_r = btn_r_up | btn_r_dwn;
  assign pc           = ry + PH / 2;
  assign bc           = by + BSZ / 2;
  assign cpu_dn       = (pc + CSPD < bc);
  assign cpu_up       = (pc > bc + CSPD);
  assign r_next       = paddle_step(r_paddle_y, cpu_up, cpu_dn, CSPD);
`else
  assign r_next = paddle_step(r_paddle_y, btn_r_up, btn_r_dwn, PSPD);
`endif

  assign state = st;

  // Game FSM plus all positional and score state; advances only on tick, reset wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      st          <= SERVE;
      cnt         <= '0;
      ball_x      <= X_CTR;
      ball_y      <= Y_CTR;
      l_paddle_y  <= P_CTR;
      r_paddle_y  <= P_CTR;
      score_l     <= '0;
      score_r     <= '0;
      dx_right    <= 1'b1;
      dy_down     <= 1'b1;
      left_scored <= 1'b0;
      game_over   <= 1'b0;
    end else if (tick) begin
      // Paddles move in every state except GAME_OVER.
      if (st != GAME_OVER) begin
        l_paddle_y <= l_next;
        r_paddle_y <= r_next;
      end

      case (st)
        SERVE: begin
          ball_x <= X_CTR;
          ball_y <= Y_CTR;
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            st  <= PLAY;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        PLAY: begin
          // Vertical: bounce off bottom/top walls, clamping to the wall.
          if (dy_down && (by + BSPD >= Y_MAX)) begin
            ball_y  <= Y_MAX_N;
            dy_down <= 1'b0;
          end else if (!dy_down && (by <= BSPD)) begin
            ball_y  <= '0;
            dy_down <= 1'b1;
          end else if (dy_down) begin
            ball_y <= ball_y + BSPD_N;
          end else begin
            ball_y <= ball_y - BSPD_N;
          end

          // Horizontal: paddle face reflects, passing the screen edge scores.
          if (!dx_right) begin
            if ((bx <= LFACE + BSPD) && (bx >= LFACE) && l_overlap) begin
              ball_x   <= LFACE_N;
              dx_right <= 1'b1;
            end else if (bx < BSPD) begin
              score_r     <= score_r + SCORE_W'(1);
              left_scored <= 1'b0;
              st          <= POINT;
            end else begin
              ball_x <= ball_x - BSPD_N;
            end
          end else begin
            if ((bx + BSPD >= RFACE) && (bx <= RFACE) && r_overlap) begin
              ball_x   <= RFACE_N;
              dx_right <= 1'b0;
            end else if (bx + BSPD > X_MAX) begin
              score_l     <= score_l + SCORE_W'(1);
              left_scored <= 1'b1;
              st          <= POINT;
            end else begin
              ball_x <= ball_x + BSPD_N;
            end
          end
        end

        POINT: begin
          ball_x <= X_CTR;
          ball_y <= Y_CTR;
          if ((left_scored ? score_l : score_r) == WIN) begin
            st        <= GAME_OVER;
            game_over <= 1'b1;
          end else begin
            // Next serve heads toward whoever conceded the point.
            dx_right <= left_scored;
            cnt      <= '0;
            st       <= SERVE;
          end
        end

        GAME_OVER: begin
          ball_x <= X_CTR;
          ball_y <= Y_CTR;
          if (start) begin
            score_l    <= '0;
            score_r    <= '0;
            l_paddle_y <= P_CTR;
            r_paddle_y <= P_CTR;
            cnt        <= '0;
            game_over  <= 1'b0;
            st         <= SERVE;
          end
        end

        default: st <= SERVE;
      endcase
    end
  end

endmodule

// File: tb/tb_pong_engine.sv
// Directed bench for pong_engine (default build, human right paddle).
// Ticks are pulsed one cycle on, one cycle off; outputs are sampled on the falling edge.
// Expected values are hand-derived positions along known rallies.
module tb_pong_engine;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       btn_l_up = 1'b0, btn_l_dwn = 1'b0, btn_r_up = 1'b0, btn_r_dwn = 1'b0;
  logic       start = 1'b0;
  logic [9:0] ball_x, ball_y, l_paddle_y, r_paddle_y;
  logic [3:0] score_l, score_r;
  logic [1:0] state;
  logic       game_over;

  int total = 0;
  int bad   = 0;
  int n;

  pong_engine dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .btn_l_up   (btn_l_up),
    .btn_l_dwn  (btn_l_dwn),
    .btn_r_up   (btn_r_up),
    .btn_r_dwn  (btn_r_dwn),
    .start      (start),
    .ball_x     (ball_x),
    .ball_y     (ball_y),
    .l_paddle_y (l_paddle_y),
    .r_paddle_y (r_paddle_y),
    .score_l    (score_l),
    .score_r    (score_r),
    .state      (state),
    .game_over  (game_over)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_ticks(input int cnt);
    repeat (cnt) begin
      @(negedge clk);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
    end
  endtask

  // Tick until state reaches target or the budget runs out; returns ticks used.
  task automatic tick_until_state(input logic [1:0] target, input int limit, output int used);
    used = 0;
    while (state !== target && used < limit) begin
      do_ticks(1);
      used++;
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_bx"}, 32'(ball_x), 316);
    chk({tag, "_by"}, 32'(ball_y), 236);
    chk({tag, "_lp"}, 32'(l_paddle_y), 208);
    chk({tag, "_rp"}, 32'(r_paddle_y), 208);
    chk({tag, "_sl"}, 32'(score_l), 0);
    chk({tag, "_sr"}, 32'(score_r), 0);
    chk({tag, "_st"}, 32'(state), 0);
    chk({tag, "_go"}, 32'(game_over), 0);
  endtask

  initial begin
    // Reset, with a tick present while rst is high.
    repeat (2) @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    rst  = 1'b0;
    chk_reset("rst");

    // Paddles up during serve: 4 px/tick, saturate at 0.
    btn_l_up = 1'b1;
    btn_r_up = 1'b1;
    do_ticks(1);
    chk("lp_t1", 32'(l_paddle_y), 204);
    chk("st_t1", 32'(state), 0);
    do_ticks(50);
    chk("lp_t51", 32'(l_paddle_y), 4);
    do_ticks(1);
    chk("lp_t52", 32'(l_paddle_y), 0);
    chk("rp_t52", 32'(r_paddle_y), 0);
    do_ticks(1);
    chk("lp_sat", 32'(l_paddle_y), 0);
    btn_r_up  = 1'b0;
    btn_l_up  = 1'b0;
    btn_l_dwn = 1'b1;
    do_ticks(1);
    chk("lp_dn", 32'(l_paddle_y), 4);
    btn_l_up = 1'b1;
    do_ticks(4);
    chk("lp_both", 32'(l_paddle_y), 4);
    chk("rp_hold", 32'(r_paddle_y), 0);
    btn_l_up  = 1'b0;
    btn_l_dwn = 1'b0;

    // Serve length: still SERVE after 59 ticks, PLAY after the 60th.
    do_ticks(1);
    chk("st_t59", 32'(state), 0);
    do_ticks(1);
    chk("st_t60", 32'(state), 1);
    chk("bx_t60", 32'(ball_x), 316);
    do_ticks(1);
    chk("bx_p1", 32'(ball_x), 318);
    chk("by_p1", 32'(ball_y), 238);

    // No tick: nothing moves.
    repeat (3) @(negedge clk);
    chk("bx_idle", 32'(ball_x), 318);
    chk("by_idle", 32'(ball_y), 238);

    // Bottom wall bounce: 470 -> clamp 472 -> 470.
    do_ticks(116);
    chk("by_p117", 32'(ball_y), 470);
    chk("bx_p117", 32'(ball_x), 550);
    do_ticks(1);
    chk("by_p118", 32'(ball_y), 472);
    do_ticks(1);
    chk("by_p119", 32'(ball_y), 470);
    chk("bx_p119", 32'(ball_x), 554);

    // Right paddle at 0 misses the ball: reaches 632, then left scores.
    do_ticks(39);
    chk("bx_p158", 32'(ball_x), 632);
    chk("by_p158", 32'(ball_y), 392);
    chk("st_p158", 32'(state), 1);
    do_ticks(1);
    chk("st_point", 32'(state), 2);
    chk("sl_point", 32'(score_l), 1);
    chk("bx_point", 32'(ball_x), 632);
    chk("by_point", 32'(ball_y), 390);
    do_ticks(1);
    chk("st_reserve", 32'(state), 0);
    chk("bx_reserve", 32'(ball_x), 316);
    chk("by_reserve", 32'(ball_y), 236);
    chk("sl_reserve", 32'(score_l), 1);

    // Rally 2: right paddle back to 208; serve heads right again, dy now up.
    btn_r_dwn = 1'b1;
    do_ticks(52);
    chk("rp_back", 32'(r_paddle_y), 208);
    btn_r_dwn = 1'b0;
    do_ticks(8);
    chk("st_r2", 32'(state), 1);
    do_ticks(1);
    chk("bx_r2p1", 32'(ball_x), 318);
    chk("by_r2p1", 32'(ball_y), 234);
    tick_until_state(2'd2, 400, n);
    chk("r2_len", 32'(n), 158);
    chk("sl_r2", 32'(score_l), 2);

    // Rallies 3..9: each 60 serve + 159 play ticks.
    for (int r = 3; r <= 9; r++) begin
      do_ticks(1);
      chk("st_serve_r", 32'(state), 0);
      tick_until_state(2'd2, 400, n);
      chk("rally_len", 32'(n), 219);
      chk("sl_rally", 32'(score_l), 32'(r));
    end
    chk("sr_r9", 32'(score_r), 0);
    do_ticks(1);
    chk("st_go", 32'(state), 3);
    chk("go_flag", 32'(game_over), 1);
    chk("bx_go", 32'(ball_x), 316);
    chk("by_go", 32'(ball_y), 236);

    // GAME_OVER holds without start; paddles frozen.
    btn_l_dwn = 1'b1;
    do_ticks(2);
    chk("st_go_hold", 32'(state), 3);
    chk("lp_frozen", 32'(l_paddle_y), 4);
    chk("sl_go_hold", 32'(score_l), 9);
    btn_l_dwn = 1'b0;
    start = 1'b1;
    do_ticks(1);
    start = 1'b0;
    chk_reset("restart");

    // Restart rally: right paddle at 0 meets the ball at y=54 and reflects it.
    btn_r_up = 1'b1;
    do_ticks(52);
    chk("rp_top", 32'(r_paddle_y), 0);
    btn_r_up = 1'b0;
    do_ticks(8);
    chk("st_rs", 32'(state), 1);
    do_ticks(145);
    chk("bx_pre_hit", 32'(ball_x), 606);
    chk("by_pre_hit", 32'(ball_y), 54);
    do_ticks(1);
    chk("bx_hit", 32'(ball_x), 608);
    chk("by_hit", 32'(ball_y), 56);
    do_ticks(1);
    chk("bx_after_hit", 32'(ball_x), 606);
    chk("by_after_hit", 32'(ball_y), 58);

    // Ball passes the left paddle (at 208) and right scores.
    tick_until_state(2'd2, 400, n);
    chk("left_miss_len", 32'(n), 304);
    chk("sr_left_miss", 32'(score_r), 1);
    chk("sl_left_miss", 32'(score_l), 0);
    chk("bx_left_miss", 32'(ball_x), 0);
    chk("by_left_miss", 32'(ball_y), 278);
    do_ticks(1);
    chk("st_after_lm", 32'(state), 0);
    do_ticks(60);
    do_ticks(1);
    chk("bx_serve_left", 32'(ball_x), 314);
    chk("by_serve_left", 32'(ball_y), 234);
    do_ticks(10);
    chk("bx_mid", 32'(ball_x), 294);
    chk("st_mid", 32'(state), 1);

    // Reset mid-rally without a tick.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_reset("mid_rst");
    rst = 1'b0;
    do_ticks(1);
    chk("st_post_rst", 32'(state), 0);
    chk("bx_post_rst", 32'(ball_x), 316);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
